// File: rtl/gdsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gdsp_pkg
// Description : Shared sample type, scheduler state encoding and dot-source
//               codes for the constellation display path.
// Revision    : 1.0 - initial release
// ============================================================================
package gdsp_pkg;

    typedef logic signed [11:0] sample_t;   // Q1.11

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FULL   = 2'd2,
        FROZEN = 2'd3
    } sched_state_t;

    localparam logic DOT_SRC_RX  = 1'b0;
    localparam logic DOT_SRC_REF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dot_rr_arbiter
// Description : Two-requester round-robin arbiter with per-requester enable.
//               Requester 0 has priority after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_rr_arbiter (
    input  logic       clk_pixel,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_en,
    output logic [1:0] o_gnt
);

    logic [1:0] w_req;
    logic       r_last;     // 1 = requester 1 granted most recently

    assign w_req = i_req & i_en;

    always_comb begin
        o_gnt = 2'b00;
        if (w_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt = w_req;
        end
    end

    // Reset value makes requester 0 win the first tie
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (o_gnt[0]) begin
            r_last <= 1'b0;
        end else if (o_gnt[1]) begin
            r_last <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/constellation_dot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : constellation_dot_scheduler
// Description : Owns the dot-buffer write port: per-frame clear, slot budget,
//               RX decimation/holding and RX/reference round-robin.
//               Optional statistics ports under CONST_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module constellation_dot_scheduler
    import gdsp_pkg::*;
#(
    parameter int MAX_DOTS  = 64,
    parameter int IDX_W     = $clog2(MAX_DOTS),
    parameter int REF_SLOTS = 16,
    parameter int DECIM     = 1
) (
    input  logic             clk_pixel,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             freeze,
    input  logic             rx_valid,
    input  logic [11:0]      rx_I,
    input  logic [11:0]      rx_Q,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [11:0]      ref_I,
    input  logic [11:0]      ref_Q,
    output logic             dot_clear,
    output logic             dot_wr_en,
    output logic [IDX_W-1:0] dot_wr_idx,
    output logic [11:0]      dot_wr_I,
    output logic [11:0]      dot_wr_Q,
    output logic             dot_wr_src,
    output logic [1:0]       sched_state
`ifdef CONST_SCHED_STATS_EN
    ,
    output logic [15:0]      rx_drop_cnt,
    output logic [IDX_W:0]   frame_dots
`endif
);

    localparam logic [IDX_W:0] c_last_slot = (IDX_W+1)'(MAX_DOTS - 1);
    localparam logic [IDX_W:0] c_ref_slots = (IDX_W+1)'(REF_SLOTS);
    localparam logic [7:0]     c_decim_last = 8'(DECIM - 1);

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic [IDX_W:0] r_slot_cnt;
    logic [IDX_W:0] r_ref_cnt;
    logic [7:0]     r_dec_cnt;
    logic           r_hold_valid;
    sample_t        r_hold_I;
    sample_t        r_hold_Q;

    logic           w_can_grant;
    logic           w_kept;
    logic           w_new_frame;
    logic [1:0]     w_gnt;
    logic           w_gnt_rx;
    logic           w_gnt_ref;
    logic           w_any_gnt;

    // frame_start pre-empts any grant in its own cycle
    assign w_can_grant = (r_state == FILL) && !frame_start;
    assign w_kept      = rx_valid && (r_dec_cnt == 8'd0);
    assign w_new_frame = frame_start && !freeze;

    dot_rr_arbiter u_arb (
        .clk_pixel (clk_pixel),
        .rst       (rst),
        .i_req     ({ref_valid, r_hold_valid}),
        .i_en      ({w_can_grant && (r_ref_cnt < c_ref_slots), w_can_grant}),
        .o_gnt     (w_gnt)
    );

    assign w_gnt_rx  = w_gnt[0];
    assign w_gnt_ref = w_gnt[1];
    assign w_any_gnt = w_gnt_rx || w_gnt_ref;
    assign ref_ready = w_gnt_ref;
    assign sched_state = r_state;

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = freeze ? FROZEN : FILL;
        end else if ((r_state == FILL) && w_any_gnt && (r_slot_cnt == c_last_slot)) begin
            w_state_nxt = FULL;
        end
    end

    // Slot/ref budgets restart every frame; the write port is registered
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_ref_cnt  <= '0;
            dot_clear  <= 1'b0;
            dot_wr_en  <= 1'b0;
            dot_wr_idx <= '0;
            dot_wr_I   <= '0;
            dot_wr_Q   <= '0;
            dot_wr_src <= 1'b0;
        end else begin
            dot_clear <= w_new_frame;
            dot_wr_en <= w_any_gnt;
            if (frame_start) begin
                r_slot_cnt <= '0;
                r_ref_cnt  <= '0;
            end else begin
                if (w_any_gnt) begin
                    r_slot_cnt <= r_slot_cnt + 1'b1;
                end
                if (w_gnt_ref) begin
                    r_ref_cnt <= r_ref_cnt + 1'b1;
                end
            end
            if (w_any_gnt) begin
                dot_wr_idx <= r_slot_cnt[IDX_W-1:0];
                dot_wr_I   <= w_gnt_ref ? ref_I : r_hold_I;
                dot_wr_Q   <= w_gnt_ref ? ref_Q : r_hold_Q;
                dot_wr_src <= w_gnt_ref ? DOT_SRC_REF : DOT_SRC_RX;
            end
        end
    end

    // RX decimation and 1-deep holding register run in every state
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_dec_cnt    <= 8'd0;
            r_hold_valid <= 1'b0;
            r_hold_I     <= '0;
            r_hold_Q     <= '0;
        end else begin
            if (rx_valid) begin
                r_dec_cnt <= (r_dec_cnt == c_decim_last) ? 8'd0 : r_dec_cnt + 8'd1;
            end
            if (w_kept) begin
                r_hold_valid <= 1'b1;
                r_hold_I     <= rx_I;
                r_hold_Q     <= rx_Q;
            end else if (w_gnt_rx) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

`ifdef CONST_SCHED_STATS_EN
    logic w_drop;

    assign w_drop = w_kept && ((r_state == FULL) || (r_state == FROZEN) ||
                               (r_hold_valid && !w_gnt_rx));

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            rx_drop_cnt <= 16'd0;
            frame_dots  <= '0;
        end else begin
            if (w_drop && (rx_drop_cnt != 16'hFFFF)) begin
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
            end
            if (frame_start) begin
                frame_dots <= r_slot_cnt;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_constellation_dot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_constellation_dot_scheduler
// Description : Directed self-checking bench; a DECIM=1 and a DECIM=4 instance
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_constellation_dot_scheduler;

    logic        clk_pixel = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        freeze = 1'b0;
    logic        rx_valid = 1'b0;
    logic [11:0] rx_I = '0;
    logic [11:0] rx_Q = '0;
    logic        ref_valid = 1'b0;
    logic [11:0] ref_I = '0;
    logic [11:0] ref_Q = '0;

    logic        ref_ready, dot_clear, dot_wr_en, dot_wr_src;
    logic [5:0]  dot_wr_idx;
    logic [11:0] dot_wr_I, dot_wr_Q;
    logic [1:0]  sched_state;

    logic        d4_ref_ready, d4_dot_clear, d4_dot_wr_en, d4_dot_wr_src;
    logic [5:0]  d4_dot_wr_idx;
    logic [11:0] d4_dot_wr_I, d4_dot_wr_Q;
    logic [1:0]  d4_sched_state;

`ifdef CONST_SCHED_STATS_EN
    logic [15:0] rx_drop_cnt, d4_rx_drop_cnt;
    logic [6:0]  frame_dots, d4_frame_dots;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    constellation_dot_scheduler #(.MAX_DOTS(64), .REF_SLOTS(16), .DECIM(1)) dut (
        .clk_pixel (clk_pixel), .rst (rst), .frame_start (frame_start), .freeze (freeze),
        .rx_valid (rx_valid), .rx_I (rx_I), .rx_Q (rx_Q),
        .ref_valid (ref_valid), .ref_ready (ref_ready), .ref_I (ref_I), .ref_Q (ref_Q),
        .dot_clear (dot_clear), .dot_wr_en (dot_wr_en), .dot_wr_idx (dot_wr_idx),
        .dot_wr_I (dot_wr_I), .dot_wr_Q (dot_wr_Q), .dot_wr_src (dot_wr_src),
        .sched_state (sched_state)
`ifdef CONST_SCHED_STATS_EN
        , .rx_drop_cnt (rx_drop_cnt), .frame_dots (frame_dots)
`endif
    );

    constellation_dot_scheduler #(.MAX_DOTS(64), .REF_SLOTS(16), .DECIM(4)) dut_d4 (
        .clk_pixel (clk_pixel), .rst (rst), .frame_start (frame_start), .freeze (freeze),
        .rx_valid (rx_valid), .rx_I (rx_I), .rx_Q (rx_Q),
        .ref_valid (ref_valid), .ref_ready (d4_ref_ready), .ref_I (ref_I), .ref_Q (ref_Q),
        .dot_clear (d4_dot_clear), .dot_wr_en (d4_dot_wr_en), .dot_wr_idx (d4_dot_wr_idx),
        .dot_wr_I (d4_dot_wr_I), .dot_wr_Q (d4_dot_wr_Q), .dot_wr_src (d4_dot_wr_src),
        .sched_state (d4_sched_state)
`ifdef CONST_SCHED_STATS_EN
        , .rx_drop_cnt (d4_rx_drop_cnt), .frame_dots (d4_frame_dots)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic pulse_frame(input logic frz);
        frame_start = 1'b1;
        freeze      = frz;
        tick();
        frame_start = 1'b0;
        freeze      = 1'b0;
    endtask

    initial begin
        int wr;
        int hs;
        int w4;
        logic exp_src;

        // ---------------- reset state
        tick(); tick();
        chk("rst_outputs", {dot_clear, dot_wr_en, dot_wr_idx, dot_wr_I, dot_wr_Q,
                            dot_wr_src, sched_state, ref_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_state", sched_state, 32'd0);

        // ---------------- 10 RX strobes, DECIM=1
        pulse_frame(1'b0);
        chk("t1_clear", dot_clear, 32'd1);
        chk("t1_clear_nowr", dot_wr_en, 32'd0);
        chk("t1_state_fill", sched_state, 32'd1);
        for (int k = 0; k < 10; k++) begin
            rx_valid = 1'b1;
            rx_I     = 12'd648;
            rx_Q     = 12'hD78;
            tick();
            rx_valid = 1'b0;
            chk("t1_nowr_capture", dot_wr_en, 32'd0);
            tick();
            chk("t1_wr_en", dot_wr_en, 32'd1);
            chk("t1_wr_idx", dot_wr_idx, k);
            chk("t1_wr_src", dot_wr_src, 32'd0);
            chk("t1_wr_I", dot_wr_I, 32'd648);
            chk("t1_wr_Q", dot_wr_Q, 32'hD78);
            if (k == 0) chk("t1_clear_done", dot_clear, 32'd0);
            tick();
            tick();
        end

        // ---------------- reference budget: 40 offered, 16 accepted
        pulse_frame(1'b0);
        chk("t2_clear", dot_clear, 32'd1);
        ref_valid = 1'b1;
        hs = 0;
        wr = 0;
        for (int c = 0; c < 40; c++) begin
            ref_I = 12'(100 + hs);
            ref_Q = 12'(200 + hs);
            #1;
            if (ref_ready) hs++;
            tick();
            if (dot_wr_en) begin
                chk("t2_wr_idx", dot_wr_idx, wr);
                chk("t2_wr_src", dot_wr_src, 32'd1);
                chk("t2_wr_I", dot_wr_I, 100 + wr);
                wr++;
            end
        end
        ref_valid = 1'b0;
        chk("t2_handshakes", hs, 32'd16);
        chk("t2_writes", wr, 32'd16);
        chk("t2_still_fill", sched_state, 32'd1);

        // ---------------- DECIM=4: 20 strobes -> strobes 1,5,9,13,17 written
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_frame(1'b0);
        w4 = 0;
        for (int k = 0; k < 20; k++) begin
            rx_valid = 1'b1;
            rx_I     = 12'(10 * k + 1);
            rx_Q     = 12'd5;
            tick();
            rx_valid = 1'b0;
            tick();
            if (d4_dot_wr_en) begin
                chk("t3_d4_idx", d4_dot_wr_idx, w4);
                chk("t3_d4_I", d4_dot_wr_I, 10 * (4 * w4) + 1);
                w4++;
            end
            tick();
            tick();
        end
        chk("t3_d4_writes", w4, 32'd5);

        // ---------------- RX every cycle plus ref: alternate, then fill to FULL
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_frame(1'b0);
        wr = 0;
        hs = 0;
        for (int c = 0; c < 80; c++) begin
            rx_valid  = 1'b1;
            ref_valid = 1'b1;
            rx_I      = 12'(c);
            #1;
            if (ref_ready) hs++;
            tick();
            if (dot_wr_en) begin
                exp_src = (wr < 32) && (wr % 2 == 0);
                chk("t4_wr_idx", dot_wr_idx, wr);
                chk("t4_wr_src", dot_wr_src, exp_src);
                wr++;
            end
        end
        chk("t4_writes", wr, 32'd64);
        chk("t4_ref_hs", hs, 32'd16);
        chk("t4_state_full", sched_state, 32'd2);

        // ---------------- freeze frame, then normal frame
        rx_valid  = 1'b0;
        ref_valid = 1'b0;
        pulse_frame(1'b1);
        chk("t5_no_clear", dot_clear, 32'd0);
        chk("t5_frozen", sched_state, 32'd3);
        wr = 0;
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            rx_valid  = 1'b1;
            ref_valid = 1'b1;
            rx_I      = 12'(12'h300 + c);
            #1;
            if (ref_ready) hs++;
            tick();
            if (dot_wr_en) wr++;
        end
        rx_valid  = 1'b0;
        ref_valid = 1'b0;
        chk("t5_frozen_writes", wr, 32'd0);
        chk("t5_frozen_ready", hs, 32'd0);
        chk("t5_still_frozen", sched_state, 32'd3);
        pulse_frame(1'b0);
        chk("t5_clear", dot_clear, 32'd1);
        chk("t5_clear_nowr", dot_wr_en, 32'd0);
        chk("t5_fill", sched_state, 32'd1);
        tick();
        chk("t5_wr_en", dot_wr_en, 32'd1);
        chk("t5_wr_idx", dot_wr_idx, 32'd0);
        chk("t5_wr_I", dot_wr_I, 32'h309);

        // ---------------- frame_start collides with a pending RX grant
        rx_valid = 1'b1;
        rx_I     = 12'h123;
        rx_Q     = 12'h456;
        tick();
        rx_valid    = 1'b0;
        frame_start = 1'b1;
        ref_valid   = 1'b1;
        #1;
        chk("t6_fs_ref_ready", ref_ready, 32'd0);
        tick();
        frame_start = 1'b0;
        ref_valid   = 1'b0;
        chk("t6_clear", dot_clear, 32'd1);
        chk("t6_clear_nowr", dot_wr_en, 32'd0);
        tick();
        chk("t6_held_wr", dot_wr_en, 32'd1);
        chk("t6_held_idx", dot_wr_idx, 32'd0);
        chk("t6_held_I", dot_wr_I, 32'h123);
        chk("t6_held_Q", dot_wr_Q, 32'h456);

        // ---------------- reset mid-FILL
        rx_valid = 1'b1;
        rx_I     = 12'h7FF;
        tick();
        rx_valid = 1'b0;
        tick();
        chk("t6_pre_rst_wr", {dot_wr_en, dot_wr_idx}, {1'b1, 6'd1});
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {dot_clear, dot_wr_en, dot_wr_idx, dot_wr_I, dot_wr_Q,
                               dot_wr_src, sched_state, ref_ready}, 32'd0);
        tick();
        rst = 1'b0;
        wr = 0;
        hs = 0;
        for (int c = 0; c < 8; c++) begin
            rx_valid  = 1'b1;
            ref_valid = 1'b1;
            #1;
            if (ref_ready) hs++;
            tick();
            if (dot_wr_en) wr++;
        end
        rx_valid  = 1'b0;
        ref_valid = 1'b0;
        chk("t6_idle_writes", wr, 32'd0);
        chk("t6_idle_ready", hs, 32'd0);
        chk("t6_idle_state", sched_state, 32'd0);
        pulse_frame(1'b0);
        chk("t6_restart_state", sched_state, 32'd1);
        chk("t6_restart_clear", dot_clear, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
